ray_row_dispatcher: RTL and testbench
=====================================

// Module: ray_row_dispatcher
// PURPOSE
//  Drives the N_WORKERS Raytracing_Worker instances one screen row at a time.
//  - Issues pixel_y, pixel_y_sqrd, per-worker pixel_start_x and activate.
//  - Detects row completion through the workers' busy handshake.
//  - Snapshots all worker buffers into a line buffer.
//  - Drains the line buffer to the framebuffer write port in screen-x order, in parallel with the next row's computation.
// PARAMETERS
//  N_WORKERS        10   worker instances; SCREEN_W must equal N_WORKERS*JOBS_SUBDIVISION
//  JOBS_SUBDIVISION 64   pixels per worker per row
//  SCREEN_W         640  pixels per row
//  SCREEN_H         480  rows per frame
//  FB_ADDR_B        19   framebuffer address width; must satisfy SCREEN_W*SCREEN_H <= 2**FB_ADDR_B
// PORTS
//  clk                  in   1                          system clock
//  rst                  in   1                          synchronous, active-high reset
//  start                in   1                          1-cycle pulse: render one frame
//  frame_busy           out  1                          high from accepted start until frame_done
//  frame_done           out  1                          1-cycle pulse after last pixel is written
//  worker_activate      out  N_WORKERS                  per-worker activate, all bits equal
//  worker_start_x       out  N_WORKERS x 12 signed      worker w: -(SCREEN_W/2)+w, constant
//  pixel_y              out  `PX_Y_B signed             current row y coordinate
//  pixel_y_sqrd         out  `PX_Y_SQRD_B               pixel_y*pixel_y
//  worker_busy          in   N_WORKERS                  worker busy outputs
//  worker_buffer        in   N_WORKERS x JOBS_SUBDIVISION x Color   worker result buffers
//  fb_we                out  1                          framebuffer write strobe
//  fb_addr              out  FB_ADDR_B                  row*SCREEN_W + x_idx
//  fb_data              out  Color (12)                 pixel colour
//  fb_ready             in   1                          sink accepts the write when fb_we && fb_ready
// BEHAVIOUR
//  Reset values: all outputs 0; row=0, all seen_busy flags cleared; FSM in IDLE; line buffer not valid.
//  Row mapping:
//  - pixel_y = SCREEN_H/2 - row, for row 0..SCREEN_H-1 (range +240..-239).
//  - pixel_y_sqrd is registered from pixel_y in SETUP and held stable while activate is high.
//  Compute FSM:
//  - IDLE: frame_busy=0. start -> SETUP, row=0, frame_busy=1. start is ignored when not in IDLE.
//  - SETUP, 1 cycle: load pixel_y and pixel_y_sqrd -> ACTIVATE.
//  - ACTIVATE: worker_activate = all ones. For each worker w, seen_busy[w] is set once worker_busy[w]==1.
//    When every seen_busy bit is set -> WAIT_DONE.
//    Workers raise busy one cycle after activate, so busy is never sampled as "done" before it has been seen high.
//  - WAIT_DONE: activate stays high. When worker_busy == 0 for all workers -> RELEASE.
//  - RELEASE: worker_activate=0, held for exactly 1 cycle so workers return to READY with current_job=0.
//    Clear all seen_busy bits.
//    - Line buffer free: copy every worker_buffer into the line buffer in this cycle, set it valid.
//      Then go to SETUP with row+1, or to LAST when row == SCREEN_H-1.
//    - Line buffer still draining: stay in RELEASE with activate low, copy and advance once the drain ends.
//  - LAST: wait for the drain to finish, pulse frame_done, clear frame_busy -> IDLE.
//  Drain:
//  - Runs while the line buffer is valid: x_idx 0..SCREEN_W-1, one pixel per accepted write.
//  - fb_data = line[w][k], with w = x_idx mod N_WORKERS and k = x_idx div N_WORKERS.
//    Implemented as wrap counters: w wraps at N_WORKERS-1, and k increments on each wrap.
//  - fb_addr = drain_row*SCREEN_W + x_idx, kept as an incrementing register with no multiplier.
//  - fb_ready=0 holds fb_we, fb_addr and fb_data stable.
//  - The buffer frees in the cycle the x_idx=SCREEN_W-1 write is accepted.
//  - A snapshot may load in that same cycle; the next drain starts the following cycle with no bubble.
//  Reset mid-frame:
//  - Within 1 cycle: activate=0, fb_we=0, line buffer invalidated, FSM to IDLE, no frame_done.
//  - Because activate drops, the workers self-reset.
// STRUCTURE
//  - Types.sv supplies Color, `PX_Y_B, `PX_Y_SQRD_B and `BACKGROUND_COLOR.
//  - Add shared constants SCREEN_W, SCREEN_H and FB_ADDR_B there.
//  - One sub-module, ray_line_drain: snapshot register array, x_idx/w/k counters, address register and fb handshake.
//    Interface: load, line_in, row_base, busy, fb_*.
//  - ray_row_dispatcher keeps the compute FSM and the row counter.
// TESTING
//  Bench uses behavioural worker models whose busy goes high 1 cycle after activate, stays high 200 cycles,
//  and whose buffer[k] = {w[3:0], k[7:0]}.
//  1. Reset, then a start pulse:
//     pixel_y=240, pixel_y_sqrd=57600, worker_start_x[3]=-317, activate high 1 cycle after SETUP.
//  2. Row 0 drain with fb_ready=1:
//     640 writes at fb_addr 0..639; x_idx=13 gives fb_data={4'd3, 8'd1}. No gaps between writes.
//  3. fb_ready toggled 1/0 every cycle during a drain: no duplicate or dropped addresses;
//     while ready=0, fb_data and fb_addr are held.
//  4. Workers finish in 50 cycles (faster than the 640-cycle drain):
//     the dispatcher waits in RELEASE with activate=0 and never overwrites an undrained line.
//  5. Full frame: exactly 307200 writes, last fb_addr=307199 with row=479 and pixel_y=-239,
//     then a single frame_done pulse; start during the frame is ignored.
//  6. rst asserted mid-row 100: the next cycle has activate=0 and fb_we=0;
//     a new start renders from row 0.

Source files
------------

// File: rtl/ray_row_dispatcher_pkg.sv
// Shared types and screen constants for the row dispatcher and its line drain.
package ray_row_dispatcher_pkg;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int FB_ADDR_B   = 19;
  localparam int PX_Y_B      = 10;
  localparam int PX_Y_SQRD_B = 18;
  localparam int START_X_B   = 12;

  typedef logic [11:0] Color;
  localparam Color BACKGROUND_COLOR = 12'h000;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVATE, S_WAIT_DONE, S_RELEASE, S_LAST
  } state_t;
endpackage

// File: rtl/ray_row_dispatcher_if.sv
// Framebuffer write port: strobe/address/data forward, ready back.
interface ray_row_dispatcher_if #(parameter int FB_ADDR_B = 19);
  logic                        we;
  logic [FB_ADDR_B-1:0]        addr;
  ray_row_dispatcher_pkg::Color data;
  logic                        ready;

  modport master (output we, addr, data, input ready);
  modport slave  (input we, addr, data, output ready);
endinterface

// File: rtl/ray_row_dispatcher_line_drain.sv
// Line buffer snapshot plus screen-x ordered drain to the framebuffer port.
module ray_line_drain #(
  parameter int N_WORKERS        = 10,
  parameter int JOBS_SUBDIVISION = 64,
  parameter int FB_ADDR_B        = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  ray_row_dispatcher_pkg::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] i_line_in,
  input  logic [FB_ADDR_B-1:0] i_row_base,
  output logic o_busy,
  ray_row_dispatcher_if.master fb
);
  localparam int W_B = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int K_B = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

  ray_row_dispatcher_pkg::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] r_line;
  logic                 r_valid;
  logic [W_B-1:0]       r_w;
  logic [K_B-1:0]       r_k;
  logic [FB_ADDR_B-1:0] r_addr;
  logic                 w_accept, w_last_w, w_last;

  assign w_last_w = (r_w == W_B'(N_WORKERS-1));
  assign w_last   = w_last_w && (r_k == K_B'(JOBS_SUBDIVISION-1));
  assign w_accept = r_valid && fb.ready;
  // Free already in the cycle the final pixel is taken, so a new snapshot lands without a bubble.
  assign o_busy   = r_valid && !(w_accept && w_last);

  assign fb.we   = r_valid;
  assign fb.addr = r_addr;
  assign fb.data = r_valid ? r_line[r_w][r_k] : ray_row_dispatcher_pkg::BACKGROUND_COLOR;

  always_ff @(posedge clk)
    if (i_load && !o_busy) r_line <= i_line_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_w     <= '0;
      r_k     <= '0;
      r_addr  <= '0;
    end else if (i_load && !o_busy) begin
      r_valid <= 1'b1;
      r_w     <= '0;
      r_k     <= '0;
      r_addr  <= i_row_base;
    end else if (w_accept) begin
      r_addr <= r_addr + FB_ADDR_B'(1);
      if (w_last) begin
        r_valid <= 1'b0;
        r_w     <= '0;
        r_k     <= '0;
      end else if (w_last_w) begin
        r_w <= '0;
        r_k <= r_k + K_B'(1);
      end else begin
        r_w <= r_w + W_B'(1);
      end
    end
  end
endmodule

// File: rtl/ray_row_dispatcher.sv
// Row-at-a-time compute FSM for the raytracing workers; hands finished rows to the line drain.
module ray_row_dispatcher #(
  parameter int N_WORKERS        = 10,
  parameter int JOBS_SUBDIVISION = 64,
  parameter int SCREEN_W         = ray_row_dispatcher_pkg::SCREEN_W,
  parameter int SCREEN_H         = ray_row_dispatcher_pkg::SCREEN_H,
  parameter int FB_ADDR_B        = ray_row_dispatcher_pkg::FB_ADDR_B
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_frame_busy,
  output logic o_frame_done,
  output logic [N_WORKERS-1:0] o_worker_activate,
  output logic [N_WORKERS-1:0][ray_row_dispatcher_pkg::START_X_B-1:0] o_worker_start_x,
  output logic signed [ray_row_dispatcher_pkg::PX_Y_B-1:0] o_pixel_y,
  output logic [ray_row_dispatcher_pkg::PX_Y_SQRD_B-1:0] o_pixel_y_sqrd,
  input  logic [N_WORKERS-1:0] i_worker_busy,
  input  ray_row_dispatcher_pkg::Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] i_worker_buffer,
  ray_row_dispatcher_if.master fb
);
  import ray_row_dispatcher_pkg::*;

  localparam int ROW_B = $clog2(SCREEN_H);

  state_t                          r_state;
  logic [ROW_B-1:0]                r_row;
  logic [FB_ADDR_B-1:0]            r_row_base;
  logic [N_WORKERS-1:0]            r_seen, w_seen;
  logic                            r_activate, r_frame_busy, r_frame_done;
  logic signed [PX_Y_B-1:0]        r_pixel_y, w_y;
  logic signed [PX_Y_SQRD_B-1:0]   w_y_ext;
  logic [PX_Y_SQRD_B-1:0]          r_pixel_y_sqrd;
  logic [N_WORKERS-1:0][START_X_B-1:0] r_start_x;
  logic                            w_drain_busy, w_load;

  assign w_y     = PX_Y_B'(SCREEN_H/2) - PX_Y_B'(r_row);
  assign w_y_ext = PX_Y_SQRD_B'(w_y);
  assign w_seen  = r_seen | i_worker_busy;
  assign w_load  = (r_state == S_RELEASE) && !w_drain_busy;

  assign o_frame_busy      = r_frame_busy;
  assign o_frame_done      = r_frame_done;
  assign o_worker_activate = {N_WORKERS{r_activate}};
  assign o_worker_start_x  = r_start_x;
  assign o_pixel_y         = r_pixel_y;
  assign o_pixel_y_sqrd    = r_pixel_y_sqrd;

  always_ff @(posedge clk)
    for (int w = 0; w < N_WORKERS; w++)
      r_start_x[w] <= rst ? '0 : START_X_B'(w - SCREEN_W/2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_row_base     <= '0;
      r_seen         <= '0;
      r_activate     <= 1'b0;
      r_frame_busy   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_pixel_y      <= '0;
      r_pixel_y_sqrd <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state      <= S_SETUP;
          r_row        <= '0;
          r_row_base   <= '0;
          r_seen       <= '0;
          r_frame_busy <= 1'b1;
        end
        S_SETUP: begin
          r_pixel_y      <= w_y;
          r_pixel_y_sqrd <= w_y_ext * w_y_ext;
          r_activate     <= 1'b1;
          r_state        <= S_ACTIVATE;
        end
        // Busy must be seen high first, otherwise idle workers would read as done.
        S_ACTIVATE: begin
          r_seen <= w_seen;
          if (&w_seen) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: if (i_worker_busy == '0) begin
          r_activate <= 1'b0;
          r_state    <= S_RELEASE;
        end
        S_RELEASE: begin
          r_seen <= '0;
          if (!w_drain_busy) begin
            if (r_row == ROW_B'(SCREEN_H-1)) begin
              r_state <= S_LAST;
            end else begin
              r_row      <= r_row + ROW_B'(1);
              r_row_base <= r_row_base + FB_ADDR_B'(SCREEN_W);
              r_state    <= S_SETUP;
            end
          end
        end
        S_LAST: if (!w_drain_busy) begin
          r_frame_done <= 1'b1;
          r_frame_busy <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ray_line_drain #(
    .N_WORKERS(N_WORKERS), .JOBS_SUBDIVISION(JOBS_SUBDIVISION), .FB_ADDR_B(FB_ADDR_B)
  ) u_drain (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_line_in(i_worker_buffer),
    .i_row_base(r_row_base),
    .o_busy(w_drain_busy),
    .fb(fb)
  );
endmodule

// File: tb/tb_ray_row_dispatcher.sv
// Directed bench: behavioural workers, framebuffer sink monitor, hand-computed expectations.
module tb_ray_row_dispatcher;
  import ray_row_dispatcher_pkg::*;

  localparam int NW = 10, JS = 4, SW = 40, SH = 480, AB = 15;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  logic                         frame_busy, frame_done;
  logic [NW-1:0]                act, wbusy;
  logic [NW-1:0][START_X_B-1:0] start_x;
  logic signed [PX_Y_B-1:0]     pixel_y;
  logic [PX_Y_SQRD_B-1:0]       pixel_y_sqrd;
  Color [NW-1:0][JS-1:0]        wbuf;

  ray_row_dispatcher_if #(.FB_ADDR_B(AB)) fb();

  ray_row_dispatcher #(
    .N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .SCREEN_W(SW), .SCREEN_H(SH), .FB_ADDR_B(AB)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start),
    .o_frame_busy(frame_busy), .o_frame_done(frame_done),
    .o_worker_activate(act), .o_worker_start_x(start_x),
    .o_pixel_y(pixel_y), .o_pixel_y_sqrd(pixel_y_sqrd),
    .i_worker_busy(wbusy), .i_worker_buffer(wbuf),
    .fb(fb)
  );

  for (genvar w = 0; w < NW; w++) begin : g_w
    for (genvar k = 0; k < JS; k++) begin : g_k
      assign wbuf[w][k] = {4'(w), 8'(k)};
    end
  end

  // worker model: busy one cycle after activate, for busy_len cycles
  int   busy_len = 200;
  logic mbusy = 1'b0, mdone = 1'b0;
  int   mcnt = 0;
  always @(posedge clk) begin
    if (!act[0]) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
    end else if (!mbusy && !mdone) begin
      mbusy <= 1'b1;
      mcnt  <= busy_len - 1;
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mbusy <= 1'b0;
        mdone <= 1'b1;
      end else mcnt <= mcnt - 1;
    end
  end
  assign wbusy = {NW{mbusy}};

  // ready: 0 always high, 1 toggling, 2 always low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    fb.ready = (rdy_mode == 1) ? ~fb.ready : (rdy_mode == 0);
  end

  int   cyc = 0;
  int   nwr, addr_err, data_err, hold_err, stall_cnt, done_cnt, wr_at_done;
  int   last_addr, exp_addr, d13, first_cyc, last_cyc;
  logic prev_stall;
  logic [AB-1:0] prev_addr;
  Color prev_data;

  function automatic Color exp_pix(int a);
    int x, w, k;
    x = a % SW;
    w = x % NW;
    k = x / NW;
    return {4'(w), 8'(k)};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      wr_at_done = nwr;
    end
    if (prev_stall && (!fb.we || fb.addr != prev_addr || fb.data != prev_data)) hold_err++;
    prev_stall = fb.we && !fb.ready;
    prev_addr  = fb.addr;
    prev_data  = fb.data;
    if (fb.we && !fb.ready) stall_cnt++;
    if (fb.we && fb.ready) begin
      if (int'(fb.addr) != exp_addr) addr_err++;
      if (fb.data != exp_pix(int'(fb.addr))) data_err++;
      if (fb.addr == AB'(13)) d13 = int'(fb.data);
      if (nwr == 0) first_cyc = cyc;
      last_cyc  = cyc;
      last_addr = int'(fb.addr);
      exp_addr++;
      nwr++;
    end
  end

  task automatic mon_clear();
    nwr = 0; addr_err = 0; data_err = 0; hold_err = 0; stall_cnt = 0;
    done_cnt = 0; wr_at_done = 0; last_addr = -1; exp_addr = 0; d13 = -1;
    first_cyc = 0; last_cyc = 0; prev_stall = 1'b0;
  endtask

  int n_chk = 0, n_err = 0;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_clear();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_wr(int n, int budget);
    for (int i = 0; i < budget && nwr < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then start
    mon_clear();
    do_reset();
    chk("rst_act", int'(act), 0);
    chk("rst_we", int'(fb.we), 0);
    chk("rst_frame_busy", int'(frame_busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_pixel_y", int'(pixel_y), 0);
    chk("rst_addr", int'(fb.addr), 0);
    pulse_start();
    chk("setup_frame_busy", int'(frame_busy), 1);
    chk("setup_act", int'(act), 0);
    @(posedge clk); #1;
    chk("act_all", int'(act), 1023);
    chk("pixel_y_row0", int'(pixel_y), 240);
    chk("pixel_y_sqrd_row0", int'(pixel_y_sqrd), 57600);
    chk("start_x3", int'($signed(start_x[3])), -17);
    chk("start_x0", int'($signed(start_x[0])), -20);

    // 2: row 0 drain, ready high
    wait_wr(40, 600);
    chk("row0_writes", nwr, 40);
    chk("row0_addr_order", addr_err, 0);
    chk("row0_data", data_err, 0);
    chk("x13_data", d13, 12'h301);
    chk("row0_no_gaps", last_cyc - first_cyc, 39);
    chk("row0_last_addr", last_addr, 39);
    chk("row1_pixel_y", int'(pixel_y), 239);

    // 3: toggling ready during row 1 drain
    rdy_mode = 1;
    wait_wr(80, 800);
    rdy_mode = 0;
    chk("tog_writes", nwr, 80);
    chk("tog_addr_order", addr_err, 0);
    chk("tog_data", data_err, 0);
    chk("tog_hold", hold_err, 0);
    chk("tog_stalled", int'(stall_cnt >= 39), 1);

    // 4: fast workers, blocked sink: dispatcher parks in RELEASE
    do_reset();
    busy_len = 5;
    rdy_mode = 2;
    pulse_start();
    repeat (100) @(posedge clk); #1;
    chk("park_act", int'(act), 0);
    chk("park_pixel_y", int'(pixel_y), 239);
    chk("park_writes", nwr, 0);
    chk("park_we", int'(fb.we), 1);
    repeat (50) @(posedge clk); #1;
    chk("park_act_late", int'(act), 0);
    chk("park_addr_held", int'(fb.addr), 0);
    rdy_mode = 0;
    wait_wr(120, 600);
    chk("park_writes_after", nwr, 120);
    chk("park_addr_order", addr_err, 0);
    chk("park_data", data_err, 0);
    chk("park_hold", hold_err, 0);

    // 5: full frame, with a stray start mid-frame
    do_reset();
    busy_len = 20;
    pulse_start();
    repeat (500) @(posedge clk); #1;
    pulse_start();
    for (int i = 0; i < 30000 && done_cnt == 0; i++) @(posedge clk);
    repeat (50) @(posedge clk); #1;
    chk("frame_done_count", done_cnt, 1);
    chk("frame_writes_at_done", wr_at_done, SW * SH);
    chk("frame_writes", nwr, SW * SH);
    chk("frame_last_addr", last_addr, SW * SH - 1);
    chk("frame_addr_order", addr_err, 0);
    chk("frame_data", data_err, 0);
    chk("frame_no_bubble", last_cyc - first_cyc, SW * SH - 1);
    chk("frame_busy_end", int'(frame_busy), 0);
    chk("frame_last_pixel_y", int'(pixel_y), -239);
    chk("frame_act_end", int'(act), 0);

    // 6: reset in the middle of row 100
    do_reset();
    pulse_start();
    for (int i = 0; i < 10000 && pixel_y != 10'sd140; i++) @(posedge clk);
    repeat (10) @(posedge clk); #1;
    chk("row100_pixel_y", int'(pixel_y), 140);
    chk("row100_act", int'(act), 1023);
    chk("row100_we", int'(fb.we), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_act", int'(act), 0);
    chk("midrst_we", int'(fb.we), 0);
    chk("midrst_frame_busy", int'(frame_busy), 0);
    rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("midrst_no_done", done_cnt, 0);
    mon_clear();
    pulse_start();
    @(posedge clk); #1;
    chk("restart_pixel_y", int'(pixel_y), 240);
    wait_wr(40, 600);
    chk("restart_writes", nwr, 40);
    chk("restart_last_addr", last_addr, 39);
    chk("restart_addr_order", addr_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
